// File: rtl/spu_pkg.sv
// Shared SPU constants, the issue request bundle, and the latency-to-countdown mapping.
package spu_pkg;

    localparam int QUADWORD       = 128;
    localparam int REG_COUNT      = 128;
    localparam int REG_ADDR_WIDTH = 7;
    localparam int LAT_WIDTH      = 3;

    // srcs[2]/[1]/[0] = ra/rb/rc, with src_used bits in the same order.
    typedef struct packed {
        logic                           valid;
        logic [2:0][REG_ADDR_WIDTH-1:0] srcs;
        logic [2:0]                     src_used;
        logic [REG_ADDR_WIDTH-1:0]      rt;
        logic                           wr_en;
        logic [LAT_WIDTH-1:0]           lat;
    } issue_req_t;

    // The issue cycle is the first latency cycle, so a write with latency L
    // stays busy for L-1 cycles after issue. A latency of 0 is treated as 1.
    function automatic logic [LAT_WIDTH-1:0] lat_to_cnt(input logic [LAT_WIDTH-1:0] lat);
        return (lat == '0) ? '0 : lat - LAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown: cycles left until a register's pending write-back lands.
module sb_entry
    import spu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 set,
    input  logic [LAT_WIDTH-1:0] set_val,
    output logic                 busy
);

    logic [LAT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (set)
            cnt_d = set_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - LAT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: RAW/WAW/intra-pair hazard gating for the SPU register file.
// Optional stall counters are built when SCOREBOARD_STATS_EN is defined.
module reg_scoreboard
    import spu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      issue_valid_even,
    input  logic [REG_ADDR_WIDTH-1:0] ra_even,
    input  logic [REG_ADDR_WIDTH-1:0] rb_even,
    input  logic [REG_ADDR_WIDTH-1:0] rc_even,
    input  logic [2:0]                src_used_even,
    input  logic [REG_ADDR_WIDTH-1:0] rt_even,
    input  logic                      wr_en_even,
    input  logic [LAT_WIDTH-1:0]      lat_even,
    input  logic                      issue_valid_odd,
    input  logic [REG_ADDR_WIDTH-1:0] ra_odd,
    input  logic [REG_ADDR_WIDTH-1:0] rb_odd,
    input  logic [1:0]                src_used_odd,
    input  logic [REG_ADDR_WIDTH-1:0] rt_odd,
    input  logic                      wr_en_odd,
    input  logic [LAT_WIDTH-1:0]      lat_odd,
    output logic                      stall_even,
    output logic                      stall_odd,
    output logic                      fire_even,
    output logic                      fire_odd,
    output logic [REG_COUNT-1:0]      busy_vec
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]               stall_cycles_even,
    output logic [31:0]               stall_cycles_odd
`endif
);

    issue_req_t req_even, req_odd;
    logic       src_haz_even, src_haz_odd, pair_hazard;

    function automatic logic src_hazard(input issue_req_t req, input logic [REG_COUNT-1:0] busy);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++)
            if (req.src_used[i] && busy[req.srcs[i]])
                hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        req_even.valid    = issue_valid_even;
        req_even.srcs     = {ra_even, rb_even, rc_even};
        req_even.src_used = src_used_even;
        req_even.rt       = rt_even;
        req_even.wr_en    = wr_en_even;
        req_even.lat      = lat_even;
        // The odd pipe has no third source; its slot is tied off as unused.
        req_odd.valid     = issue_valid_odd;
        req_odd.srcs      = {ra_odd, rb_odd, REG_ADDR_WIDTH'(0)};
        req_odd.src_used  = {src_used_odd, 1'b0};
        req_odd.rt        = rt_odd;
        req_odd.wr_en     = wr_en_odd;
        req_odd.lat       = lat_odd;
    end

    always_comb begin
        src_haz_even = src_hazard(req_even, busy_vec);
        src_haz_odd  = src_hazard(req_odd, busy_vec);
        stall_even   = req_even.valid &
                       (src_haz_even | (req_even.wr_en & busy_vec[req_even.rt]));
        pair_hazard  = 1'b0;
        if (req_even.valid && !stall_even && req_even.wr_en) begin
            for (int i = 0; i < 3; i++)
                if (req_odd.src_used[i] && (req_odd.srcs[i] == req_even.rt))
                    pair_hazard = 1'b1;
            if (req_odd.wr_en && (req_odd.rt == req_even.rt))
                pair_hazard = 1'b1;
        end
        stall_odd = req_odd.valid &
                    (stall_even | src_haz_odd | (req_odd.wr_en & busy_vec[req_odd.rt]) | pair_hazard);
        fire_even = req_even.valid & ~stall_even & ~flush;
        fire_odd  = req_odd.valid & ~stall_odd & ~flush;
    end

    logic [LAT_WIDTH-1:0] cnt_even, cnt_odd;
    assign cnt_even = lat_to_cnt(req_even.lat);
    assign cnt_odd  = lat_to_cnt(req_odd.lat);

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_entry
        logic set_even, set_odd;
        assign set_even = fire_even & req_even.wr_en & (req_even.rt == REG_ADDR_WIDTH'(r));
        assign set_odd  = fire_odd & req_odd.wr_en & (req_odd.rt == REG_ADDR_WIDTH'(r));
        sb_entry u_entry (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .set     (set_even | set_odd),
            .set_val (set_even ? cnt_even : cnt_odd),
            .busy    (busy_vec[r])
        );
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_even_q, stall_odd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_even_q <= '0;
            stall_odd_q  <= '0;
        end else begin
            if (stall_even && (stall_even_q != '1))
                stall_even_q <= stall_even_q + 32'd1;
            if (stall_odd && (stall_odd_q != '1))
                stall_odd_q <= stall_odd_q + 32'd1;
        end
    end

    assign stall_cycles_even = stall_even_q;
    assign stall_cycles_odd  = stall_odd_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (stall counters checked when SCOREBOARD_STATS_EN is set).
module tb_reg_scoreboard;
    import spu_pkg::*;

    logic clk = 1'b0;
    logic reset, flush;
    logic issue_valid_even, wr_en_even, issue_valid_odd, wr_en_odd;
    logic [REG_ADDR_WIDTH-1:0] ra_even, rb_even, rc_even, rt_even, ra_odd, rb_odd, rt_odd;
    logic [2:0] src_used_even;
    logic [1:0] src_used_odd;
    logic [LAT_WIDTH-1:0] lat_even, lat_odd;
    logic stall_even, stall_odd, fire_even, fire_odd;
    logic [REG_COUNT-1:0] busy_vec;
    logic [REG_COUNT-1:0] exp_busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_even, stall_cycles_odd;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid_even(issue_valid_even), .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
        .src_used_even(src_used_even), .rt_even(rt_even), .wr_en_even(wr_en_even), .lat_even(lat_even),
        .issue_valid_odd(issue_valid_odd), .ra_odd(ra_odd), .rb_odd(rb_odd), .src_used_odd(src_used_odd),
        .rt_odd(rt_odd), .wr_en_odd(wr_en_odd), .lat_odd(lat_odd),
        .stall_even(stall_even), .stall_odd(stall_odd), .fire_even(fire_even), .fire_odd(fire_odd),
        .busy_vec(busy_vec)
`ifdef SCOREBOARD_STATS_EN
        , .stall_cycles_even(stall_cycles_even), .stall_cycles_odd(stall_cycles_odd)
`endif
    );

    task automatic idle();
        flush = 0;
        issue_valid_even = 0; ra_even = '0; rb_even = '0; rc_even = '0; src_used_even = '0;
        rt_even = '0; wr_en_even = 0; lat_even = '0;
        issue_valid_odd = 0; ra_odd = '0; rb_odd = '0; src_used_odd = '0;
        rt_odd = '0; wr_en_odd = 0; lat_odd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        #3;
        checks++; if (busy_vec !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
        checks++; if ({stall_even, stall_odd, fire_even, fire_odd} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {stall_even, stall_odd, fire_even, fire_odd}); end
        #9 reset = 0;
        tick();
    endtask

    task automatic test_raw_even();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd5; lat_even = 3'd4;
        #3;
        checks++; if (fire_even !== 1'b1 || stall_even !== 1'b0) begin
            failures++; $display("FAIL raw_issue fire=%b stall=%b exp fire=1 stall=0", fire_even, stall_even); end
        tick();
        wr_en_even = 0; ra_even = 7'd5; src_used_even = 3'b100;
        exp_busy = '0; exp_busy[5] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #3;
            checks++; if (stall_even !== 1'b1 || fire_even !== 1'b0 || busy_vec !== exp_busy) begin
                failures++; $display("FAIL raw_stall cyc=%0d stall=%b fire=%b busy=%h exp stall=1 fire=0 busy=%h",
                                     c, stall_even, fire_even, busy_vec, exp_busy); end
            tick();
        end
        #3;
        checks++; if (stall_even !== 1'b0 || fire_even !== 1'b1 || busy_vec !== '0) begin
            failures++; $display("FAIL raw_free stall=%b fire=%b busy=%h exp stall=0 fire=1 busy=0",
                                 stall_even, fire_even, busy_vec); end
        tick();
        idle();
    endtask

    task automatic test_pair_raw();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd10; lat_even = 3'd2;
        issue_valid_odd = 1; ra_odd = 7'd10; src_used_odd = 2'b10;
        #3;
        checks++; if (fire_even !== 1'b1 || stall_odd !== 1'b1 || fire_odd !== 1'b0) begin
            failures++; $display("FAIL pair_raw fe=%b so=%b fo=%b exp 1 1 0", fire_even, stall_odd, fire_odd); end
        tick();
        issue_valid_even = 0;
        #3;
        checks++; if (stall_odd !== 1'b1 || fire_odd !== 1'b0) begin
            failures++; $display("FAIL pair_raw_wait so=%b fo=%b exp 1 0", stall_odd, fire_odd); end
        tick();
        #3;
        checks++; if (stall_odd !== 1'b0 || fire_odd !== 1'b1) begin
            failures++; $display("FAIL pair_raw_fire so=%b fo=%b exp 0 1", stall_odd, fire_odd); end
        tick();
        idle();
    endtask

    task automatic test_in_order();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd3; lat_even = 3'd3;
        tick();
        wr_en_even = 0; rb_even = 7'd3; src_used_even = 3'b010;
        issue_valid_odd = 1; ra_odd = 7'd21; src_used_odd = 2'b10; wr_en_odd = 1; rt_odd = 7'd20; lat_odd = 3'd0;
        for (int c = 1; c <= 2; c++) begin
            #3;
            checks++; if (stall_even !== 1'b1 || stall_odd !== 1'b1 || fire_odd !== 1'b0) begin
                failures++; $display("FAIL in_order cyc=%0d se=%b so=%b fo=%b exp 1 1 0",
                                     c, stall_even, stall_odd, fire_odd); end
            tick();
        end
        #3;
        checks++; if (fire_even !== 1'b1 || fire_odd !== 1'b1) begin
            failures++; $display("FAIL in_order_fire fe=%b fo=%b exp 1 1", fire_even, fire_odd); end
        tick();
        idle();
        #3;
        checks++; if (busy_vec !== '0) begin
            failures++; $display("FAIL lat0_not_busy got=%h exp=0", busy_vec); end
        tick();
    endtask

    task automatic test_waw();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd7; lat_even = 3'd6;
        issue_valid_odd = 1; wr_en_odd = 1; rt_odd = 7'd7; lat_odd = 3'd6;
        #3;
        checks++; if (fire_even !== 1'b1 || stall_odd !== 1'b1 || fire_odd !== 1'b0) begin
            failures++; $display("FAIL waw_pair fe=%b so=%b fo=%b exp 1 1 0", fire_even, stall_odd, fire_odd); end
        tick();
        issue_valid_even = 0;
        exp_busy = '0; exp_busy[7] = 1'b1;
        #3;
        checks++; if (stall_odd !== 1'b1 || busy_vec !== exp_busy) begin
            failures++; $display("FAIL waw_busy so=%b busy=%h exp so=1 busy=%h", stall_odd, busy_vec, exp_busy); end
        tick();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_flush();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd1; lat_even = 3'd6;
        tick();
        flush = 1;
        ra_even = 7'd2; src_used_even = 3'b100; rt_even = 7'd9; lat_even = 3'd3;
        issue_valid_odd = 1; ra_odd = 7'd11; src_used_odd = 2'b10;
        exp_busy = '0; exp_busy[1] = 1'b1;
        #3;
        checks++; if (fire_even !== 1'b0 || fire_odd !== 1'b0 || stall_even !== 1'b0 || busy_vec !== exp_busy) begin
            failures++; $display("FAIL flush_fire fe=%b fo=%b se=%b busy=%h exp 0 0 0 busy=%h",
                                 fire_even, fire_odd, stall_even, busy_vec, exp_busy); end
        tick();
        idle();
        issue_valid_even = 1; ra_even = 7'd1; src_used_even = 3'b100;
        #3;
        checks++; if (busy_vec !== '0 || fire_even !== 1'b1) begin
            failures++; $display("FAIL flush_clear busy=%h fe=%b exp busy=0 fe=1", busy_vec, fire_even); end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd2; lat_even = 3'd5;
        tick();
        idle();
        exp_busy = '0; exp_busy[2] = 1'b1;
        #2;
        checks++; if (busy_vec !== exp_busy) begin
            failures++; $display("FAIL pre_reset_busy got=%h exp=%h", busy_vec, exp_busy); end
        #1 reset = 1;
        #1;
        checks++; if (busy_vec !== '0) begin
            failures++; $display("FAIL async_reset_busy got=%h exp=0", busy_vec); end
        #2 reset = 0;
        tick();
`ifdef SCOREBOARD_STATS_EN
        checks++; if (stall_cycles_even !== 32'd0 || stall_cycles_odd !== 32'd0) begin
            failures++; $display("FAIL stats_reset even=%0d odd=%0d exp 0 0", stall_cycles_even, stall_cycles_odd); end
        issue_valid_even = 1; wr_en_even = 1; rt_even = 7'd2; lat_even = 3'd5;
        tick();
        wr_en_even = 0; ra_even = 7'd2; src_used_even = 3'b100;
        issue_valid_odd = 1; ra_odd = 7'd30; src_used_odd = 2'b10;
        for (int c = 0; c < 3; c++) tick();
        idle();
        #3;
        checks++; if (stall_cycles_even !== 32'd3 || stall_cycles_odd !== 32'd3) begin
            failures++; $display("FAIL stats_count even=%0d odd=%0d exp 3 3", stall_cycles_even, stall_cycles_odd); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_raw_even();
        test_pair_raw();
        test_in_order();
        test_waw();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
